// File: rtl/rcu_bulk.sv
`default_nettype none
// ============================================================================
//  Module      : rcu_bulk
//  Description : USB receive control unit. Frames SYNC, PID, payload, CRC16
//                and EOP from decoded bytes, forwards payload to the RX FIFO
//                through a two-byte holding line so the CRC is never written,
//                and reports handshake PIDs and data-packet status.
//  Revision    : 1.0  initial release
// ============================================================================
module rcu_bulk #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    input  logic             eop,
    input  logic             crc_ok,
    input  logic             fifo_full,
    output logic             rcving,
    output logic             w_enable,
    output logic [7:0]       rx_data,
    output logic [3:0]       rx_pid,
    output logic             rx_ack,
    output logic             rx_nack,
    output logic             data_ok,
    output logic             pkt_abort,
    output logic             r_error,
    output logic [CNT_W-1:0] byte_count
);

    localparam logic [7:0]       c_sync    = 8'h80;
    localparam logic [7:0]       c_data0   = 8'hC3;
    localparam logic [7:0]       c_data1   = 8'h4B;
    localparam logic [7:0]       c_ack     = 8'hD2;
    localparam logic [7:0]       c_nak     = 8'h5A;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        WAIT_PID  = 3'd2,
        RECV_DATA = 3'd3,
        HS_EOP    = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6,
        EIDLE     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       hold0_q, hold0_d;     // oldest byte in the holding line
    logic [7:0]       hold1_q, hold1_d;
    logic [1:0]       hcnt_q, hcnt_d;       // bytes currently held (0..2)
    logic [3:0]       pid_q, pid_d;         // PID of the packet in progress
    logic             err_eop_q, err_eop_d; // eop seen in the cycle that failed
    logic             rcving_q, rcving_d;
    logic             w_enable_q, w_enable_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [3:0]       rx_pid_q, rx_pid_d;
    logic             rx_ack_q, rx_ack_d;
    logic             rx_nack_q, rx_nack_d;
    logic             data_ok_q, data_ok_d;
    logic             pkt_abort_q, pkt_abort_d;
    logic             r_error_q, r_error_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             err_go;
    logic             done_go;

    // Next-state logic: the byte of a cycle is handled first, then eop is
    // judged against the updated state and holding line.
    always_comb begin
        state_d      = state_q;
        hold0_d      = hold0_q;
        hold1_d      = hold1_q;
        hcnt_d       = hcnt_q;
        pid_d        = pid_q;
        err_eop_d    = 1'b0;
        rcving_d     = rcving_q;
        w_enable_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_pid_d     = rx_pid_q;
        rx_ack_d     = 1'b0;
        rx_nack_d    = 1'b0;
        data_ok_d    = 1'b0;
        pkt_abort_d  = 1'b0;
        r_error_d    = r_error_q;
        byte_count_d = byte_count_q;
        err_go       = 1'b0;
        done_go      = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d      = WAIT_SYNC;
                    rcving_d     = 1'b1;
                    r_error_d    = 1'b0;
                    byte_count_d = '0;
                    hcnt_d       = 2'd0;
                end
            end
            WAIT_SYNC: begin
                if (byte_received) begin
                    if (rcv_data == c_sync) state_d = WAIT_PID;
                    else                    err_go  = 1'b1;
                end
                if (eop) err_go = 1'b1;
            end
            WAIT_PID: begin
                if (byte_received) begin
                    pid_d = rcv_data[3:0];
                    if (rcv_data[7:4] != ~rcv_data[3:0]) begin
                        err_go = 1'b1;
                    end else if (rcv_data == c_data0 || rcv_data == c_data1) begin
                        state_d = RECV_DATA;
                        hcnt_d  = 2'd0;
                    end else if (rcv_data == c_ack || rcv_data == c_nak) begin
                        state_d = HS_EOP;
                    end else begin
                        err_go = 1'b1;
                    end
                end
                // A handshake PID arriving together with eop is a complete packet.
                if (eop) begin
                    if (!err_go && state_d == HS_EOP) done_go = 1'b1;
                    else                              err_go  = 1'b1;
                end
            end
            RECV_DATA: begin
                if (byte_received) begin
                    if (hcnt_q == 2'd2) begin
                        if (fifo_full || byte_count_q == c_cnt_max) begin
                            err_go = 1'b1;
                        end else begin
                            w_enable_d   = 1'b1;
                            rx_data_d    = hold0_q;
                            byte_count_d = byte_count_q + c_cnt_one;
                            hold0_d      = hold1_q;
                            hold1_d      = rcv_data;
                        end
                    end else begin
                        if (hcnt_q == 2'd0) hold0_d = rcv_data;
                        else                hold1_d = rcv_data;
                        hcnt_d = hcnt_q + 2'd1;
                    end
                end
                // The two bytes left in the holding line are the CRC.
                if (eop && !err_go) begin
                    if (hcnt_d != 2'd2 || !crc_ok) err_go  = 1'b1;
                    else                           done_go = 1'b1;
                end
            end
            HS_EOP: begin
                if (byte_received) err_go = 1'b1;
                if (eop && !err_go) done_go = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (err_eop_q || eop) begin
                    state_d  = IDLE;
                    rcving_d = 1'b0;
                end else begin
                    state_d = EIDLE;
                end
            end
            EIDLE: begin
                if (eop) begin
                    state_d  = IDLE;
                    rcving_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_go) begin
            state_d     = ERR;
            r_error_d   = 1'b1;
            pkt_abort_d = (byte_count_d != '0);
            err_eop_d   = eop;
            hcnt_d      = 2'd0;
        end else if (done_go) begin
            state_d  = DONE;
            rcving_d = 1'b0;
            rx_pid_d = pid_d;
            hcnt_d   = 2'd0;
            case (pid_d)
                c_ack[3:0]: rx_ack_d  = 1'b1;
                c_nak[3:0]: rx_nack_d = 1'b1;
                default:    data_ok_d = 1'b1;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold0_q      <= 8'h00;
            hold1_q      <= 8'h00;
            hcnt_q       <= 2'd0;
            pid_q        <= 4'h0;
            err_eop_q    <= 1'b0;
            rcving_q     <= 1'b0;
            w_enable_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_pid_q     <= 4'h0;
            rx_ack_q     <= 1'b0;
            rx_nack_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            pkt_abort_q  <= 1'b0;
            r_error_q    <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            hcnt_q       <= hcnt_d;
            pid_q        <= pid_d;
            err_eop_q    <= err_eop_d;
            rcving_q     <= rcving_d;
            w_enable_q   <= w_enable_d;
            rx_data_q    <= rx_data_d;
            rx_pid_q     <= rx_pid_d;
            rx_ack_q     <= rx_ack_d;
            rx_nack_q    <= rx_nack_d;
            data_ok_q    <= data_ok_d;
            pkt_abort_q  <= pkt_abort_d;
            r_error_q    <= r_error_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign rcving     = rcving_q;
    assign w_enable   = w_enable_q;
    assign rx_data    = rx_data_q;
    assign rx_pid     = rx_pid_q;
    assign rx_ack     = rx_ack_q;
    assign rx_nack    = rx_nack_q;
    assign data_ok    = data_ok_q;
    assign pkt_abort  = pkt_abort_q;
    assign r_error    = r_error_q;
    assign byte_count = byte_count_q;

endmodule
`default_nettype wire
